reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//   Multi-read-port register file with a bit-masked write and optional write-through bypass.
//   Read latency selects 0 (comb) or 1 (registered) cycles. A sequenced clear FSM sweeps
//   every entry to CLR_VAL after reset or on request. Holds line/frame control words for the
//   video frame-buffer pipeline where several consumers read the same table concurrently.
// PARAMETERS
//   DATA_WIDTH  10  bits per entry
//   ADDR_WIDTH  2   address bits; depth = 2**ADDR_WIDTH
//   NUM_RD      2   number of independent read ports (>=1)
//   REG_RD      0   0: combinational read; 1: registered read (1-cycle latency)
//   BYPASS      1   1: read of the address written this cycle returns new (merged) data
//   CLR_VAL     0   DATA_WIDTH-bit value written to every entry by the clear sweep
// PORTS
//   clk      in   1                     clock, all state on rising edge
//   rst_n    in   1                     async active-low reset
//   clr      in   1                     request clear sweep (1-cycle pulse sufficient)
//   busy     out  1                     1 while clear sweep in progress
//   wr_en    in   1                     write strobe
//   w_addr   in   ADDR_WIDTH            write address
//   w_data   in   DATA_WIDTH            write data
//   w_mask   in   DATA_WIDTH            per-bit write enable (1 = update bit)
//   wr_drop  out  1                     write rejected this cycle (comb: wr_en & (busy|clr))
//   r_addr   in   NUM_RD*ADDR_WIDTH     read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   r_data   out  NUM_RD*DATA_WIDTH     read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//   Reset (rst_n=0, async): FSM->CLEAR, sweep ptr=0, busy=1, REG_RD r_data regs=0.
//     Array contents not reset directly; cleared by the sweep.
//   FSM IDLE: clr=1 -> CLEAR, ptr=0 on the same edge. CLEAR: each cycle write CLR_VAL to
//     entry ptr, ptr++; after entry 2**ADDR_WIDTH-1 written -> IDLE. Sweep = 2**ADDR_WIDTH cycles.
//     First IDLE cycle after rst_n deassert follows exactly 2**ADDR_WIDTH edges.
//   clr while in CLEAR: ignored (no restart). busy = (state==CLEAR).
//   Write (IDLE, clr=0, wr_en=1): arr[w_addr] <= (arr & ~w_mask) | (w_data & w_mask).
//     w_mask=0 -> no change. Write with busy=1 or clr=1 is dropped; wr_drop=1 that cycle.
//   Read: REG_RD=0: r_data_k = arr[r_addr_k] combinationally. REG_RD=1: sampled at edge,
//     valid the cycle after r_addr is presented. Ports fully independent; same address ok.
//   While busy=1 every port returns CLR_VAL (REG_RD=1: on the cycle after busy is sampled).
//   Bypass (BYPASS=1): REG_RD=0 with r_addr_k==w_addr and an accepted write -> r_data_k =
//     merged new value in the same cycle. REG_RD=1: the registered read returns post-write
//     value (write-first). BYPASS=0, REG_RD=0: old value until the edge.
//     BYPASS=0, REG_RD=1: read-first (old value).
//   Address wrap: none needed; all ADDR_WIDTH codes valid.
//   rst_n asserted mid-sweep or mid-write: sweep restarts from entry 0; in-flight write lost.
// TESTING
//   T1 reset: rst_n low 3 cyc, release -> busy=1 for exactly 4 cyc (ADDR_WIDTH=2); all
//      r_data=0; wr_en pulsed during busy -> wr_drop=1, entry unchanged.
//   T2 write/read: wr addr1=0x155 mask=0x3FF; r_addr0=1,r_addr1=1 -> both ports 0x155
//      (REG_RD=0 same cycle after edge; REG_RD=1 one cycle later).
//   T3 mask: entry2=0x3FF, write 0x000 mask=0x00F -> entry2 reads 0x3F0.
//   T4 bypass: BYPASS=1,REG_RD=0, write addr3=0x2AA while r_addr0=3 -> r_data0=0x2AA same
//      cycle; BYPASS=0 -> old value, 0x2AA next cycle.
//   T5 clr: fill all 4 entries, pulse clr with wr_en to addr0 -> wr_drop=1, busy 4 cyc, all
//      entries CLR_VAL after; clr re-pulsed mid-sweep -> sweep length unchanged.
//   T6 reset mid-sweep: assert rst_n at sweep cycle 2 -> busy restarts, 4 full cycles after release.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: clear control, masked write port and NUM_RD read ports.
// The master side (producer/consumers) drives requests; the slave side is the register file.
interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_RD     = 2
);

  logic                         clr;
  logic                         busy;
  logic                         wr_en;
  logic [ADDR_WIDTH-1:0]        w_addr;
  logic [DATA_WIDTH-1:0]        w_data;
  logic [DATA_WIDTH-1:0]        w_mask;
  logic                         wr_drop;
  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] r_data;

  modport master (
    output clr,
    output wr_en,
    output w_addr,
    output w_data,
    output w_mask,
    output r_addr,
    input  busy,
    input  wr_drop,
    input  r_data
  );

  modport slave (
    input  clr,
    input  wr_en,
    input  w_addr,
    input  w_data,
    input  w_mask,
    input  r_addr,
    output busy,
    output wr_drop,
    output r_data
  );

endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with bit-masked writes and optional write-through bypass.
// A two-state FSM sweeps CLR_VAL into every entry after reset or on a clear request;
// during the sweep writes are dropped and all read ports return CLR_VAL.
module reg_file_mp #(
  parameter int                    DATA_WIDTH = 10,
  parameter int                    ADDR_WIDTH = 2,
  parameter int                    NUM_RD     = 2,
  parameter int                    REG_RD     = 0,
  parameter int                    BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] CLR_VAL    = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                state_d, state_q;
  logic [ADDR_WIDTH-1:0] ptr_d, ptr_q;

  // Storage array; contents are initialised by the sweep, never by reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  busy;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Clear-sweep FSM: next state and sweep pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        // clr is ignored here so a re-pulse never lengthens the sweep.
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (&ptr_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // FSM state register; reset lands in CLEAR so the array is swept after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy        = (state_q == ST_CLEAR);
  assign wr_acc      = !busy && !bus.clr && bus.wr_en;
  assign wr_old      = mem_q[bus.w_addr];
  assign wr_merged   = (wr_old & ~bus.w_mask) | (bus.w_data & bus.w_mask);
  assign bus.busy    = busy;
  assign bus.wr_drop = bus.wr_en & (busy | bus.clr);

  // Single array write port shared between the sweep and accepted user writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.w_addr;
    mem_wdata = wr_merged;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = CLR_VAL;
    end else if (wr_acc) begin
      mem_we    = 1'b1;
    end
  end

  // Array write; unmasked bits are preserved through the read-modify-merge above.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Independent read ports.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd_old;
      logic [DATA_WIDTH-1:0] rd_new;

      assign ra     = bus.r_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd_old = mem_q[ra];

      // Write-through: forward the merged word when this port hits the accepted write.
      always_comb begin
        rd_new = rd_old;
        if ((BYPASS != 0) && wr_acc && (ra == bus.w_addr)) begin
          rd_new = wr_merged;
        end
      end

      if (REG_RD == 0) begin : g_comb
        assign bus.r_data[gi*DATA_WIDTH +: DATA_WIDTH] = busy ? CLR_VAL : rd_new;
      end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_d, rd_q;

        // Registered read value; CLR_VAL while the sweep is running.
        always_comb begin
          rd_d = rd_new;
          if (busy) begin
            rd_d = CLR_VAL;
          end
        end

        // Read-data register, one cycle of latency.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            rd_q <= '0;
          end else begin
            rd_q <= rd_d;
          end
        end

        assign bus.r_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp. Three instances share one stimulus stream:
//   a: REG_RD=0 BYPASS=1, b: REG_RD=1 BYPASS=1, c: REG_RD=0 BYPASS=0.
// Registered-read expectations are queued when stimulus is applied and popped a cycle later.
module tb_reg_file_mp;

  localparam int DW    = 10;
  localparam int AW    = 2;
  localparam int NR    = 2;
  localparam int DEPTH = 4;

  typedef logic [NR*DW-1:0] rd_vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) if_a ();
  reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) if_b ();
  reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) if_c ();

  assign if_b.clr    = if_a.clr;
  assign if_b.wr_en  = if_a.wr_en;
  assign if_b.w_addr = if_a.w_addr;
  assign if_b.w_data = if_a.w_data;
  assign if_b.w_mask = if_a.w_mask;
  assign if_b.r_addr = if_a.r_addr;
  assign if_c.clr    = if_a.clr;
  assign if_c.wr_en  = if_a.wr_en;
  assign if_c.w_addr = if_a.w_addr;
  assign if_c.w_data = if_a.w_data;
  assign if_c.w_mask = if_a.w_mask;
  assign if_c.r_addr = if_a.r_addr;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .REG_RD(0), .BYPASS(1),
                .CLR_VAL(10'h000)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .REG_RD(1), .BYPASS(1),
                .CLR_VAL(10'h000)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .REG_RD(0), .BYPASS(0),
                .CLR_VAL(10'h000)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_busy;
  logic [AW-1:0] m_ptr;
  rd_vec_t       qb[$];

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic    obs_busy;
  logic    obs_drop;
  rd_vec_t obs_a, obs_b, obs_c;

  task automatic set_idle();
    if_a.clr    = 1'b0;
    if_a.wr_en  = 1'b0;
    if_a.w_addr = '0;
    if_a.w_data = '0;
    if_a.w_mask = '0;
    if_a.r_addr = '0;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    if_a.wr_en  = 1'b1;
    if_a.w_addr = a;
    if_a.w_data = d;
    if_a.w_mask = m;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    if_a.r_addr = {a1, a0};
  endtask

  // One clock cycle: inputs are already applied (posedge+1); compare at negedge, advance model.
  task automatic step();
    logic          acc, drop;
    logic [DW-1:0] merged;
    logic [AW-1:0] ra;
    rd_vec_t       exp_a, exp_c, exp_b;
    exp_a  = '0;
    exp_c  = '0;
    acc    = !m_busy && !if_a.clr && if_a.wr_en;
    drop   = if_a.wr_en && (m_busy || if_a.clr);
    merged = (m_mem[if_a.w_addr] & ~if_a.w_mask) | (if_a.w_data & if_a.w_mask);
    for (int k = 0; k < NR; k++) begin
      ra = if_a.r_addr[k*AW +: AW];
      if (!m_busy) begin
        exp_c[k*DW +: DW] = m_mem[ra];
        exp_a[k*DW +: DW] = (acc && (ra == if_a.w_addr)) ? merged : m_mem[ra];
      end
    end
    @(negedge clk);
    obs_busy = if_a.busy;
    obs_drop = if_a.wr_drop;
    obs_a    = if_a.r_data;
    obs_b    = if_b.r_data;
    obs_c    = if_c.r_data;
    checks++;
    if (obs_busy !== m_busy) begin
      errors++;
      $display("FAIL busy txn %0d: got %b expected %b", txn, obs_busy, m_busy);
    end
    checks++;
    if (obs_drop !== drop) begin
      errors++;
      $display("FAIL wr_drop txn %0d: got %b expected %b", txn, obs_drop, drop);
    end
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL rdata_comb_bypass txn %0d: got %h expected %h", txn, obs_a, exp_a);
    end
    checks++;
    if (obs_c !== exp_c) begin
      errors++;
      $display("FAIL rdata_comb_nobypass txn %0d: got %h expected %h", txn, obs_c, exp_c);
    end
    if (qb.size() > 0) begin
      exp_b = qb.pop_front();
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL rdata_reg txn %0d: got %h expected %h", txn, obs_b, exp_b);
      end
    end
    qb.push_back(exp_a);
    $display("txn %0d clr=%b wr=%b wa=%0d wd=%h wm=%h ra=%h | busy=%b drop=%b a=%h b=%h c=%h",
             txn, if_a.clr, if_a.wr_en, if_a.w_addr, if_a.w_data, if_a.w_mask, if_a.r_addr,
             obs_busy, obs_drop, obs_a, obs_b, obs_c);
    txn++;
    @(posedge clk);
    if (m_busy) begin
      m_mem[m_ptr] = 10'h000;
      if (m_ptr == AW'(DEPTH - 1)) m_busy = 1'b0;
      m_ptr = m_ptr + 1'b1;
    end else if (if_a.clr) begin
      m_busy = 1'b1;
      m_ptr  = '0;
    end else if (acc) begin
      m_mem[if_a.w_addr] = merged;
    end
    #1;
  endtask

  // Hold reset for n edges, checking reset outputs, release at posedge+1.
  task automatic apply_reset(input int n);
    rst_n  = 1'b0;
    m_busy = 1'b1;
    m_ptr  = '0;
    qb.delete();
    @(negedge clk);
    checks++;
    if (if_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 1", if_a.busy);
    end
    checks++;
    if (if_b.r_data !== '0) begin
      errors++;
      $display("FAIL reset_rdreg: got %h expected 0", if_b.r_data);
    end
    checks++;
    if (if_a.r_data !== '0) begin
      errors++;
      $display("FAIL reset_rdcomb: got %h expected 0", if_a.r_data);
    end
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Run cycles until busy drops (bounded), with the current inputs on the first cycle only.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if_a.clr   = 1'b0;
      if_a.wr_en = 1'b0;
      if (obs_busy) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    int n;
    set_idle();
    apply_reset(3);
    set_wr(2'd1, 10'h3FF, 10'h3FF);
    set_rd(2'd1, 2'd1);
    count_busy(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL reset_sweep_len: got %0d expected 4", n);
    end
    set_idle();
    set_rd(2'd1, 2'd1);
    step();
    checks++;
    if (obs_a !== {10'h000, 10'h000}) begin
      errors++;
      $display("FAIL reset_entry1_unchanged: got %h expected 0", obs_a);
    end
  endtask

  task automatic test_write_read();
    set_idle();
    set_wr(2'd1, 10'h155, 10'h3FF);
    set_rd(2'd1, 2'd1);
    step();
    set_idle();
    set_rd(2'd1, 2'd1);
    step();
    checks++;
    if (obs_a !== {10'h155, 10'h155}) begin
      errors++;
      $display("FAIL wr_rd_comb: got %h expected %h", obs_a, {10'h155, 10'h155});
    end
    checks++;
    if (obs_b !== {10'h155, 10'h155}) begin
      errors++;
      $display("FAIL wr_rd_reg: got %h expected %h", obs_b, {10'h155, 10'h155});
    end
  endtask

  task automatic test_mask();
    set_idle();
    set_wr(2'd2, 10'h3FF, 10'h3FF);
    step();
    set_wr(2'd2, 10'h000, 10'h00F);
    step();
    set_idle();
    set_rd(2'd2, 2'd0);
    step();
    checks++;
    if (obs_a[DW-1:0] !== 10'h3F0) begin
      errors++;
      $display("FAIL mask_comb: got %h expected 3f0", obs_a[DW-1:0]);
    end
    step();
    checks++;
    if (obs_b[DW-1:0] !== 10'h3F0) begin
      errors++;
      $display("FAIL mask_reg: got %h expected 3f0", obs_b[DW-1:0]);
    end
  endtask

  task automatic test_bypass();
    set_idle();
    set_wr(2'd3, 10'h0F0, 10'h3FF);
    step();
    set_wr(2'd3, 10'h2AA, 10'h3FF);
    set_rd(2'd3, 2'd0);
    step();
    checks++;
    if (obs_a[DW-1:0] !== 10'h2AA) begin
      errors++;
      $display("FAIL bypass_new: got %h expected 2aa", obs_a[DW-1:0]);
    end
    checks++;
    if (obs_c[DW-1:0] !== 10'h0F0) begin
      errors++;
      $display("FAIL nobypass_old: got %h expected 0f0", obs_c[DW-1:0]);
    end
    set_idle();
    set_rd(2'd3, 2'd0);
    step();
    checks++;
    if (obs_c[DW-1:0] !== 10'h2AA) begin
      errors++;
      $display("FAIL nobypass_next: got %h expected 2aa", obs_c[DW-1:0]);
    end
    checks++;
    if (obs_b[DW-1:0] !== 10'h2AA) begin
      errors++;
      $display("FAIL reg_write_first: got %h expected 2aa", obs_b[DW-1:0]);
    end
  endtask

  task automatic test_clr();
    int n;
    set_idle();
    for (int k = 0; k < DEPTH; k++) begin
      set_wr(AW'(k), DW'(10'h101 * (k + 1)), 10'h3FF);
      step();
    end
    set_idle();
    if_a.clr = 1'b1;
    set_wr(2'd0, 10'h3FF, 10'h3FF);
    step();
    checks++;
    if (obs_drop !== 1'b1) begin
      errors++;
      $display("FAIL clr_wr_drop: got %b expected 1", obs_drop);
    end
    set_idle();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if_a.clr = (i == 1);
      step();
      if (obs_busy) n++;
      else break;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL clr_sweep_len: got %0d expected 4", n);
    end
    set_idle();
    for (int k = 0; k < DEPTH; k += 2) begin
      set_rd(AW'(k), AW'(k + 1));
      step();
      checks++;
      if (obs_a !== '0) begin
        errors++;
        $display("FAIL clr_entries_%0d: got %h expected 0", k, obs_a);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    set_idle();
    set_wr(2'd1, 10'h0AB, 10'h3FF);
    step();
    set_idle();
    if_a.clr = 1'b1;
    step();
    if_a.clr = 1'b0;
    step();
    step();
    apply_reset(2);
    set_rd(2'd1, 2'd3);
    count_busy(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL midsweep_reset_len: got %0d expected 4", n);
    end
    step();
    checks++;
    if (obs_a !== '0) begin
      errors++;
      $display("FAIL midsweep_reset_cleared: got %h expected 0", obs_a);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      if_a.clr    = ($urandom_range(0, 19) == 0);
      if_a.wr_en  = ($urandom_range(0, 3) != 0);
      if_a.w_addr = AW'($urandom_range(0, DEPTH - 1));
      if_a.w_data = DW'($urandom);
      if_a.w_mask = DW'($urandom);
      if_a.r_addr = (NR*AW)'($urandom);
      step();
    end
    set_idle();
    repeat (6) step();
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    m_busy = 1'b1;
    m_ptr  = '0;
    set_idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_mask();
    test_bypass();
    test_clr();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
